coh_sampler_mc: RTL and testbench
=================================

COH_SAMPLER_MC -- requirements
Module: coh_sampler_mc

Interface
REQ-001 SHALL have parameter CH, default 4: number of independent sampling channels.
REQ-002 SHALL have parameter CW, default 8: per-channel count width.
REQ-003 SHALL have parameter PERIOD, default 960: samples per window; legal range 2..65535.
REQ-004 SHALL have port CLK  input  1  sole clock; all logic is clocked on its rising edge.
REQ-005 SHALL have port RST  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port EN  input  1  window counting enable.
REQ-007 SHALL have port MODE  input  1  0 = count ones, 1 = count rising edges.
REQ-008 SHALL have port D_IN  input  CH  asynchronous beat bits, one per channel.
REQ-009 SHALL have port COUNT  output  CH*CW  window results, channel k at bits [k*CW +: CW].
REQ-010 SHALL have port SAT  output  CH  per-channel saturation flag for the held result.
REQ-011 SHALL have port WIN_ID  output  8  sequence number of the held result.
REQ-012 SHALL have port COUNT_VALID  output  1  result-available strobe.
REQ-013 SHALL have port COUNT_READY  input  1  consumer accept.
REQ-014 SHALL have port OVF  output  1  sticky flag: a window result was dropped.

Function
REQ-015 SHALL pass each D_IN bit through a two-flop synchronizer, giving 2 cycles of latency from a D_IN change to the sampled value q.
REQ-016 SHALL keep a window position counter that advances from 0 to PERIOD-1 on each CLK while EN=1; a window is exactly PERIOD samples.
REQ-017 SHALL add one per sample: q in mode 0, or q & ~q_prev in mode 1; q_prev is continuous across window boundaries.
REQ-018 SHALL saturate each count at 2^CW-1 and set that channel's saturation bit, with no wrap-around.
REQ-019 SHALL latch MODE at window position 0; a MODE change mid-window takes effect at the next window.
REQ-020 SHALL, on the terminal sample (position PERIOD-1), form the result as the count including that sample, then restart the counts at 0 and the position at 0.
REQ-021 SHALL, on EN=0, clear the position, counts and saturation bits and report nothing for the aborted partial window.
REQ-022 SHALL, on EN rising, restart the window at position 0 on the next cycle.
REQ-023 SHALL store a new result in a one-entry output buffer when the buffer is empty, or when COUNT_VALID & COUNT_READY in the same cycle.
REQ-024 SHALL, if the buffer is full and not being drained, drop the new result and set OVF until reset.
REQ-025 SHALL assert COUNT_VALID the cycle after the terminal sample and hold it until COUNT_VALID & COUNT_READY.
REQ-026 SHALL keep COUNT, SAT and WIN_ID stable while COUNT_VALID=1.
REQ-027 SHALL increment WIN_ID once per completed window, dropped windows included, wrapping 255 -> 0; the first completed window carries 0.

Reset
REQ-028 SHALL, when RST=0, immediately clear all state: synchronizers, q_prev, position, counts, saturation bits and buffer.
REQ-029 SHALL drive COUNT=0, SAT=0, WIN_ID=0, COUNT_VALID=0 and OVF=0 during reset, including reset asserted mid-window or mid-handshake.
REQ-030 SHALL start the first window at the first CLK edge where RST=1 and EN=1.

Structure
REQ-031 SHALL place the MODE encodings (MODE_ONES=0, MODE_EDGE=1) and the parameter defaults in shared package coh_pkg.
REQ-032 SHALL derive the position counter width as clog2(PERIOD).
REQ-033 SHALL use sub-module coh_channel (synchronizer, q_prev, saturating counter, saturation bit), instantiated CH times by generate.
REQ-034 SHALL keep the position counter, mode latch, output buffer and handshake in the top-level module.

Verification (CH=2, CW=4, PERIOD=16, EN=1, COUNT_READY=1 unless stated)
REQ-035 SHALL cover: D_IN=2'b01 constant, MODE=0 -> from the second window on, ch0=15, SAT=2'b01, ch1=0, and WIN_ID increments 1, 2, 3, ...
REQ-036 SHALL cover: D_IN[0] toggling every 2 cycles, MODE=1 -> ch0=4, SAT[0]=0 in every full window.
REQ-037 SHALL cover: COUNT_READY=0 across 3 window ends -> the first result (WIN_ID=0) is held stable and OVF=1 after the second end; on release, the next result accepted carries WIN_ID=3.
REQ-038 SHALL cover: MODE switched 0 -> 1 at position 8 with D_IN[0]=1 -> current window ch0=15 (saturated ones count); next window ch0=0.
REQ-039 SHALL cover: EN=0 for 5 cycles at position 10 -> no COUNT_VALID for that window; the next result is a full 16-sample window.
REQ-040 SHALL cover: RST=0 while COUNT_VALID=1 -> COUNT_VALID, COUNT and OVF read 0 before the next CLK edge.

Source files
------------

// File: rtl/coh_pkg.sv
// Shared encodings and parameter defaults for the multi-channel beat sampler.
package coh_pkg;
  typedef enum logic {
    MODE_ONES = 1'b0,
    MODE_EDGE = 1'b1
  } mode_e;

  localparam int CH_DEF     = 4;
  localparam int CW_DEF     = 8;
  localparam int PERIOD_DEF = 960;
  localparam int WIN_ID_W   = 8;
endpackage

// File: rtl/coh_channel.sv
// One sampling channel: two-flop synchronizer, previous-sample flop and a
// saturating window counter whose result includes the current sample.
module coh_channel
  import coh_pkg::*;
#(
  parameter int CW = CW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          d_in,
  input  logic          en,
  input  mode_e         mode,
  input  logic          last,
  output logic [CW-1:0] res_count,
  output logic          res_sat
);
  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          q_prev_q, q_prev_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          sat_q, sat_d;
  logic          inc;
  logic          at_max;

  always_comb begin
    sync1_d  = d_in;
    sync2_d  = sync1_q;
    // q_prev follows q every cycle so edge detection spans window boundaries
    q_prev_d = sync2_q;
    inc      = (mode == MODE_EDGE) ? (sync2_q & ~q_prev_q) : sync2_q;
    at_max   = (cnt_q == {CW{1'b1}});
    res_count = (inc && !at_max) ? cnt_q + CW'(1) : cnt_q;
    res_sat   = sat_q | (inc & at_max);
    cnt_d = res_count;
    sat_d = res_sat;
    if (!en || last) begin
      cnt_d = '0;
      sat_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      q_prev_q <= 1'b0;
      cnt_q    <= '0;
      sat_q    <= 1'b0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      q_prev_q <= q_prev_d;
      cnt_q    <= cnt_d;
      sat_q    <= sat_d;
    end
  end
endmodule

// File: rtl/coh_sampler_mc.sv
// Multi-channel windowed beat sampler: window position, mode latch, one-entry
// result buffer with valid/ready handshake and sticky drop flag.
module coh_sampler_mc
  import coh_pkg::*;
#(
  parameter int CH     = CH_DEF,
  parameter int CW     = CW_DEF,
  parameter int PERIOD = PERIOD_DEF
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                EN,
  input  logic                MODE,
  input  logic [CH-1:0]       D_IN,
  output logic [CH*CW-1:0]    COUNT,
  output logic [CH-1:0]       SAT,
  output logic [WIN_ID_W-1:0] WIN_ID,
  output logic                COUNT_VALID,
  input  logic                COUNT_READY,
  output logic                OVF
);
  localparam int PW = (PERIOD > 1) ? $clog2(PERIOD) : 1;

  logic [PW-1:0]       pos_q, pos_d;
  mode_e               mode_q, mode_d;
  mode_e               mode_eff;
  logic                last;
  logic                drain;
  logic [CH*CW-1:0]    res_count;
  logic [CH-1:0]       res_sat;
  logic [CH*CW-1:0]    buf_count_q, buf_count_d;
  logic [CH-1:0]       buf_sat_q, buf_sat_d;
  logic [WIN_ID_W-1:0] buf_id_q, buf_id_d;
  logic [WIN_ID_W-1:0] win_cnt_q, win_cnt_d;
  logic                vld_q, vld_d;
  logic                ovf_q, ovf_d;

  genvar k;
  generate
    for (k = 0; k < CH; k++) begin : g_ch
      coh_channel #(.CW(CW)) u_ch (
        .clk       (CLK),
        .rst_n     (RST),
        .d_in      (D_IN[k]),
        .en        (EN),
        .mode      (mode_eff),
        .last      (last),
        .res_count (res_count[k*CW +: CW]),
        .res_sat   (res_sat[k])
      );
    end
  endgenerate

  always_comb begin
    // Position 0 uses MODE directly so the whole window sees one mode
    mode_eff = (pos_q == '0) ? mode_e'(MODE) : mode_q;
    last     = EN && (pos_q == PW'(PERIOD - 1));
    drain    = vld_q && COUNT_READY;

    mode_d = mode_q;
    if (EN && (pos_q == '0)) mode_d = mode_e'(MODE);

    pos_d = pos_q + PW'(1);
    if (!EN || last) pos_d = '0;

    vld_d       = vld_q & ~drain;
    buf_count_d = buf_count_q;
    buf_sat_d   = buf_sat_q;
    buf_id_d    = buf_id_q;
    win_cnt_d   = win_cnt_q;
    ovf_d       = ovf_q;
    if (last) begin
      win_cnt_d = win_cnt_q + WIN_ID_W'(1);
      if (!vld_q || drain) begin
        vld_d       = 1'b1;
        buf_count_d = res_count;
        buf_sat_d   = res_sat;
        buf_id_d    = win_cnt_q;
      end else begin
        ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      pos_q       <= '0;
      mode_q      <= MODE_ONES;
      vld_q       <= 1'b0;
      buf_count_q <= '0;
      buf_sat_q   <= '0;
      buf_id_q    <= '0;
      win_cnt_q   <= '0;
      ovf_q       <= 1'b0;
    end else begin
      pos_q       <= pos_d;
      mode_q      <= mode_d;
      vld_q       <= vld_d;
      buf_count_q <= buf_count_d;
      buf_sat_q   <= buf_sat_d;
      buf_id_q    <= buf_id_d;
      win_cnt_q   <= win_cnt_d;
      ovf_q       <= ovf_d;
    end
  end

  assign COUNT       = buf_count_q;
  assign SAT         = buf_sat_q;
  assign WIN_ID      = buf_id_q;
  assign COUNT_VALID = vld_q;
  assign OVF         = ovf_q;
endmodule

// File: tb/tb_coh_sampler_mc.sv
// Scoreboard bench for coh_sampler_mc with CH=2, CW=4, PERIOD=16.
module tb_coh_sampler_mc;
  localparam int CH     = 2;
  localparam int CW     = 4;
  localparam int PERIOD = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             en = 1'b0;
  logic             mode = 1'b0;
  logic [CH-1:0]    d_in = '0;
  logic             count_ready = 1'b1;
  logic [CH*CW-1:0] count;
  logic [CH-1:0]    sat;
  logic [7:0]       win_id;
  logic             count_valid;
  logic             ovf;

  always #5 clk = ~clk;

  coh_sampler_mc #(.CH(CH), .CW(CW), .PERIOD(PERIOD)) dut (
    .CLK         (clk),
    .RST         (rst_n),
    .EN          (en),
    .MODE        (mode),
    .D_IN        (d_in),
    .COUNT       (count),
    .SAT         (sat),
    .WIN_ID      (win_id),
    .COUNT_VALID (count_valid),
    .COUNT_READY (count_ready),
    .OVF         (ovf)
  );

  typedef struct packed {
    logic [7:0] cnt;
    logic [1:0] sat;
    logic [7:0] id;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   tog = 1'b0;
  int   tog_ph = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  task automatic push(input logic [3:0] c0, input logic [3:0] c1, input logic [1:0] s, input logic [7:0] id);
    exp_t e;
    e.cnt = {c1, c0};
    e.sat = s;
    e.id  = id;
    exp_q.push_back(e);
  endtask

  // Advance n cycles; inputs change 1 ns after the rising edge.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (tog) begin
        tog_ph++;
        d_in[0] = tog_ph[1];
      end
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    en = 1'b0;
    mode = 1'b0;
    tog = 1'b0;
    d_in = '0;
    count_ready = 1'b1;
    step(2);
    check("rst_count", 32'(count), 32'd0);
    check("rst_sat", 32'(sat), 32'd0);
    check("rst_win_id", 32'(win_id), 32'd0);
    check("rst_valid", 32'(count_valid), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    exp_q.delete();
    rst_n = 1'b1;
  endtask

  // Let the synchronizers settle with EN low, then open the first window.
  task automatic start(input logic [1:0] d, input logic m, input bit t);
    d_in = d;
    mode = m;
    tog = t;
    tog_ph = 0;
    step(4);
    en = 1'b1;
  endtask

  task automatic finish_test(input string name);
    en = 1'b0;
    step(3);
    check(name, 32'(exp_q.size()), 32'd0);
  endtask

  // Monitor: every accepted result must match the head of the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && count_valid && count_ready) begin
        check("result_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          mon_e = exp_q.pop_front();
          check("result_count", 32'(count), 32'(mon_e.cnt));
          check("result_sat", 32'(sat), 32'(mon_e.sat));
          check("result_win_id", 32'(win_id), 32'(mon_e.id));
        end
      end
    end
  end

  initial begin
    // Constant ones on ch0, ones mode: saturates every window.
    do_reset();
    start(2'b01, 1'b0, 1'b0);
    push(4'd15, 4'd0, 2'b01, 8'd0);
    push(4'd15, 4'd0, 2'b01, 8'd1);
    push(4'd15, 4'd0, 2'b01, 8'd2);
    step(48);
    finish_test("ones_drained");

    // Square wave period 4, edge mode: four rising edges per window.
    do_reset();
    start(2'b00, 1'b1, 1'b1);
    push(4'd4, 4'd0, 2'b00, 8'd0);
    push(4'd4, 4'd0, 2'b00, 8'd1);
    push(4'd4, 4'd0, 2'b00, 8'd2);
    step(48);
    finish_test("edge_drained");

    // Back-pressure across three window ends.
    do_reset();
    count_ready = 1'b0;
    start(2'b01, 1'b0, 1'b0);
    push(4'd15, 4'd0, 2'b01, 8'd0);
    push(4'd15, 4'd0, 2'b01, 8'd3);
    step(16);
    check("bp_valid_1", 32'(count_valid), 32'd1);
    check("bp_ovf_1", 32'(ovf), 32'd0);
    check("bp_count_1", 32'(count), 32'h0F);
    check("bp_id_1", 32'(win_id), 32'd0);
    step(16);
    check("bp_ovf_2", 32'(ovf), 32'd1);
    check("bp_count_2", 32'(count), 32'h0F);
    check("bp_id_2", 32'(win_id), 32'd0);
    step(16);
    check("bp_valid_3", 32'(count_valid), 32'd1);
    check("bp_id_3", 32'(win_id), 32'd0);
    check("bp_sat_3", 32'(sat), 32'd1);
    step(2);
    count_ready = 1'b1;
    step(14);
    finish_test("bp_drained");
    check("bp_ovf_sticky", 32'(ovf), 32'd1);

    // Mode switch mid-window applies from the next window.
    do_reset();
    start(2'b01, 1'b0, 1'b0);
    push(4'd15, 4'd0, 2'b01, 8'd0);
    push(4'd0, 4'd0, 2'b00, 8'd1);
    step(8);
    mode = 1'b1;
    step(24);
    finish_test("mode_drained");

    // EN dropped at position 10: partial window discarded.
    do_reset();
    start(2'b00, 1'b0, 1'b1);
    push(4'd8, 4'd0, 2'b00, 8'd0);
    step(10);
    en = 1'b0;
    step(5);
    check("abort_no_valid", 32'(count_valid), 32'd0);
    en = 1'b1;
    step(16);
    finish_test("abort_drained");

    // Asynchronous reset while a result is held.
    do_reset();
    count_ready = 1'b0;
    start(2'b01, 1'b0, 1'b0);
    step(32);
    check("ar_valid_before", 32'(count_valid), 32'd1);
    check("ar_ovf_before", 32'(ovf), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_valid", 32'(count_valid), 32'd0);
    check("ar_count", 32'(count), 32'd0);
    check("ar_ovf", 32'(ovf), 32'd0);
    check("ar_win_id", 32'(win_id), 32'd0);
    check("ar_sat", 32'(sat), 32'd0);
    do_reset();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
